// File: rtl/tb_run_controller_if.sv
// Exit/status and loader bus of the run controller.
// slave: controller side; master: harness side.
interface tb_run_controller_if #(
  parameter int NUM_EXIT_CH      = 2,
  parameter int EXIT_VALUE_WIDTH = 32,
  parameter int CNT_WIDTH        = 32
);
  localparam int CH_W =
    (NUM_EXIT_CH > 1) ? $clog2(NUM_EXIT_CH) : 1;
  localparam int VW = NUM_EXIT_CH * EXIT_VALUE_WIDTH;

  logic                        load_req_o;
  logic                        load_done_i;
  logic [NUM_EXIT_CH-1:0]      exit_valid_i;
  logic [VW-1:0]               exit_value_i;
  logic                        done_o;
  logic [1:0]                  status_o;
  logic [CH_W-1:0]             exit_ch_o;
  logic [EXIT_VALUE_WIDTH-1:0] exit_value_o;
  logic [CNT_WIDTH-1:0]        cycle_cnt_o;

  modport slave (
    input  load_done_i,
    input  exit_valid_i,
    input  exit_value_i,
    output load_req_o,
    output done_o,
    output status_o,
    output exit_ch_o,
    output exit_value_o,
    output cycle_cnt_o
  );

  modport master (
    output load_done_i,
    output exit_valid_i,
    output exit_value_i,
    input  load_req_o,
    input  done_o,
    input  status_o,
    input  exit_ch_o,
    input  exit_value_o,
    input  cycle_cnt_o
  );
endinterface

// File: rtl/tb_run_controller.sv
// Run controller: reset hold, optional load handshake,
// run-cycle timeout and sticky first-exit capture.
// Ports: clk_i, rst_i (async, active high), max_cycles_i,
// load_en_i, core_rst_no, bus (exit/status/loader slave).
module tb_run_controller #(
  parameter int NUM_EXIT_CH       = 2,
  parameter int RESET_WAIT_CYCLES = 50,
  parameter int CNT_WIDTH         = 32,
  parameter int EXIT_VALUE_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CNT_WIDTH-1:0] max_cycles_i,
  input  logic                 load_en_i,
  output logic                 core_rst_no,
  tb_run_controller_if.slave   bus
);
  localparam int CH_W =
    (NUM_EXIT_CH > 1) ? $clog2(NUM_EXIT_CH) : 1;
  localparam int HOLD_W =
    (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam int W = EXIT_VALUE_WIDTH;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  typedef enum logic [1:0] {
    S_HOLD,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [1:0]        status_q, status_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [W-1:0]      val_q, val_d;
  logic              core_rst_q, core_rst_d;
  logic              load_req;

  logic              exit_any;
  logic [CH_W-1:0]   exit_k;
  logic [W-1:0]      exit_val;
  logic              timeout;

  // Lowest-index set channel wins: scan down so the
  // last hit written is the smallest index.
  always_comb begin
    exit_any = |bus.exit_valid_i;
    exit_k   = '0;
    exit_val = '0;
    for (int k = NUM_EXIT_CH - 1; k >= 0; k--) begin
      if (bus.exit_valid_i[k]) begin
        exit_k   = CH_W'(k);
        exit_val = bus.exit_value_i[k*W +: W];
      end
    end
  end

  assign timeout = (max_cycles_i != '0) &&
                   (cnt_q >= max_cycles_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_HOLD;
      hold_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      status_q   <= ST_RUN;
      ch_q       <= '0;
      val_q      <= '0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      status_q   <= status_d;
      ch_q       <= ch_d;
      val_q      <= val_d;
      core_rst_q <= core_rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = load_en_i ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (bus.load_done_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (exit_any || timeout) state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    status_d = status_q;
    ch_d     = ch_q;
    val_d    = val_q;
    load_req = (state_q == S_LOAD);
    // Registered so the core sees reset release on
    // the same edge that enters RUN.
    core_rst_d = (state_d == S_RUN) ||
                 (state_d == S_DONE);
    unique case (state_q)
      S_HOLD: hold_d = hold_q + HOLD_W'(1);
      S_RUN: begin
        if (exit_any) begin
          ch_d     = exit_k;
          val_d    = exit_val;
          status_d = (exit_val == '0) ? ST_PASS : ST_FAIL;
          done_d   = 1'b1;
        end else if (timeout) begin
          ch_d     = '0;
          val_d    = '0;
          status_d = ST_TMO;
          done_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign core_rst_no      = core_rst_q;
  assign bus.load_req_o   = load_req;
  assign bus.done_o       = done_q;
  assign bus.status_o     = status_q;
  assign bus.exit_ch_o    = ch_q;
  assign bus.exit_value_o = val_q;
  assign bus.cycle_cnt_o  = cnt_q;
endmodule

// File: tb/tb_tb_run_controller.sv
// Self-checking bench for tb_run_controller.
// Scoreboard of expected completions, popped on done.
module tb_tb_run_controller;
  localparam int NCH = 2;
  localparam int RW  = 4;
  localparam int CW  = 8;
  localparam int VW  = 32;

  typedef struct {
    logic [1:0]    st;
    logic          ch;
    logic [VW-1:0] val;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] max_cycles = '0;
  logic          load_en = 1'b0;
  logic          core_rst_n;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  tb_run_controller_if #(
    .NUM_EXIT_CH(NCH),
    .EXIT_VALUE_WIDTH(VW),
    .CNT_WIDTH(CW)
  ) bus ();

  tb_run_controller #(
    .NUM_EXIT_CH(NCH),
    .RESET_WAIT_CYCLES(RW),
    .CNT_WIDTH(CW),
    .EXIT_VALUE_WIDTH(VW)
  ) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .max_cycles_i(max_cycles),
    .load_en_i(load_en),
    .core_rst_no(core_rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] st,
                      input logic ch,
                      input logic [VW-1:0] val,
                      input logic [CW-1:0] cnt);
    exp_t e;
    e.st = st;
    e.ch = ch;
    e.val = val;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget,
                           output int n);
    exp_t e;
    n = 0;
    while (!bus.done_o && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", bus.done_o, 1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("status", bus.status_o, e.st);
      chk("exit_ch", bus.exit_ch_o, e.ch);
      chk("exit_val", bus.exit_value_o, e.val);
      chk("cycle_cnt", bus.cycle_cnt_o, e.cnt);
    end
  endtask

  // Asserts rst mid-cycle, checks the asynchronous
  // return to reset values, then releases just after
  // an edge and checks the hold length.
  task automatic do_reset(input logic en);
    #3 rst = 1'b1;
    #1;
    chk("rst_core", core_rst_n, 0);
    chk("rst_ldreq", bus.load_req_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_status", bus.status_o, 0);
    chk("rst_ch", bus.exit_ch_o, 0);
    chk("rst_val", bus.exit_value_o, 0);
    chk("rst_cnt", bus.cycle_cnt_o, 0);
    load_en = en;
    max_cycles = '0;
    bus.exit_valid_i = '0;
    bus.exit_value_i = '0;
    bus.load_done_i = 1'b0;
    tick();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i < RW; i++) begin
      tick();
      chk("hold_core", core_rst_n, 0);
      chk("hold_ldreq", bus.load_req_o, 0);
    end
    tick();
    if (en) begin
      chk("load_entry_req", bus.load_req_o, 1);
      chk("load_entry_core", core_rst_n, 0);
    end else begin
      chk("run_entry_core", core_rst_n, 1);
      chk("run_entry_req", bus.load_req_o, 0);
      chk("run_entry_cnt", bus.cycle_cnt_o, 0);
    end
  endtask

  initial begin
    int n;
    int hi;
    bus.exit_valid_i = '0;
    bus.exit_value_i = '0;
    bus.load_done_i = 1'b0;
    tick();

    // Two exits together: ch0 wins, nonzero -> fail.
    do_reset(1'b0);
    repeat (7) tick();
    chk("pre_exit_cnt", bus.cycle_cnt_o, 7);
    bus.exit_value_i = {32'h0, 32'h5};
    bus.exit_valid_i = 2'b11;
    push(2'b10, 1'b0, 32'h5, 8'd7);
    wait_done(5, n);
    chk("exit_latency", n, 1);
    bus.exit_value_i = '0;
    bus.exit_valid_i = 2'b10;
    bus.load_done_i = 1'b1;
    max_cycles = 8'd1;
    repeat (3) tick();
    chk("frz_status", bus.status_o, 2);
    chk("frz_ch", bus.exit_ch_o, 0);
    chk("frz_val", bus.exit_value_o, 5);
    chk("frz_cnt", bus.cycle_cnt_o, 7);
    chk("frz_core", core_rst_n, 1);

    // Load handshake, exits ignored in LOAD, then
    // timeout at 20.
    do_reset(1'b1);
    bus.exit_value_i = {32'h0, 32'h7};
    bus.exit_valid_i = 2'b01;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.load_req_o) hi++;
      chk("load_core", core_rst_n, 0);
      chk("load_done_flag", bus.done_o, 0);
      if (i == 9) bus.load_done_i = 1'b1;
      tick();
    end
    bus.load_done_i = 1'b0;
    bus.exit_valid_i = '0;
    chk("load_req_cycles", hi, 10);
    chk("post_load_req", bus.load_req_o, 0);
    chk("post_load_core", core_rst_n, 1);
    chk("post_load_cnt", bus.cycle_cnt_o, 0);
    max_cycles = 8'd20;
    push(2'b11, 1'b0, 32'h0, 8'd20);
    wait_done(40, n);
    chk("tmo_cycles", n, 21);

    // Reset mid-RUN, then exit racing timeout.
    do_reset(1'b0);
    repeat (5) tick();
    chk("midrun_cnt", bus.cycle_cnt_o, 5);
    do_reset(1'b0);
    max_cycles = 8'd20;
    repeat (20) tick();
    chk("race_cnt", bus.cycle_cnt_o, 20);
    chk("race_done", bus.done_o, 0);
    bus.exit_value_i = {32'h0, 32'hAA};
    bus.exit_valid_i = 2'b10;
    push(2'b01, 1'b1, 32'h0, 8'd20);
    wait_done(5, n);
    chk("race_latency", n, 1);

    // Reset mid-LOAD.
    do_reset(1'b1);
    repeat (3) tick();
    chk("midload_req", bus.load_req_o, 1);
    do_reset(1'b0);

    // Lowering the limit below the count.
    repeat (30) tick();
    chk("lower_cnt", bus.cycle_cnt_o, 30);
    max_cycles = 8'd10;
    push(2'b11, 1'b0, 32'h0, 8'd30);
    wait_done(5, n);
    chk("lower_latency", n, 1);

    // Saturation with timeout disabled.
    do_reset(1'b0);
    repeat (300) tick();
    chk("sat_cnt", bus.cycle_cnt_o, 8'hFF);
    chk("sat_done", bus.done_o, 0);
    chk("sat_status", bus.status_o, 0);
    bus.exit_value_i = {32'h9, 32'h0};
    bus.exit_valid_i = 2'b01;
    push(2'b01, 1'b0, 32'h0, 8'hFF);
    wait_done(5, n);
    chk("pass_latency", n, 1);
    bus.exit_valid_i = '0;

    chk("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
